cpu_nibble_spi_fetch: RTL and testbench



---
 rtl/cpu_nibble_spi_fetch.sv | 132 +++++++++++++
 tb/tb_cpu_nibble_spi_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_nibble_spi_fetch.sv
// Nibble CPU fetch stage: serves 12-bit nibble reads from SPI flash
// using READ (0x03), with a one-byte line buffer for the sibling nibble.
module cpu_nibble_spi_fetch #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter bit          CACHE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic        inv,
  output logic        rsp_valid,
  output logic [3:0]  rsp_data,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [7:0]  rx_sr;
  logic [10:0] req_tag;
  logic        sel_lo;
  logic        buf_vld;
  logic [7:0]  buf_byte;
  logic [10:0] buf_tag;
  logic        accept;
  logic        hit;
  logic        last_bit;
  logic [7:0]  rx_byte;
  logic [23:0] byte_addr;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign hit       = CACHE_EN && buf_vld && !inv
                   && (buf_tag == req_addr[11:1]);
  assign byte_addr = BASE_ADDR + {13'b0, req_addr[11:1]};
  assign last_bit  = (state == SHIFT) && spi_sck
                   && (bit_cnt == 6'd39);
  assign rx_byte   = {rx_sr[6:0], spi_miso};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: hits answer at once, misses run a full transfer
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = hit ? RESP : SHIFT;
      SHIFT:   if (last_bit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SPI bit cells, line buffer fill/invalidate and response nibble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 6'd0;
      tx_sr    <= 32'd0;
      rx_sr    <= 8'd0;
      req_tag  <= 11'd0;
      sel_lo   <= 1'b0;
      buf_vld  <= 1'b0;
      buf_byte <= 8'd0;
      buf_tag  <= 11'd0;
      rsp_data <= 4'd0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      if (inv) buf_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            sel_lo <= req_addr[0];
            if (hit) begin
              rsp_data <= req_addr[0] ? buf_byte[3:0]
                                      : buf_byte[7:4];
            end else begin
              req_tag  <= req_addr[11:1];
              tx_sr    <= {8'h03, byte_addr};
              bit_cnt  <= 6'd0;
              spi_cs_n <= 1'b0;
              spi_sck  <= 1'b0;
              spi_mosi <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (!spi_sck) begin
            spi_sck <= 1'b1;
          end else begin
            spi_sck <= 1'b0;
            if (bit_cnt >= 6'd32) rx_sr <= rx_byte;
            if (last_bit) begin
              spi_cs_n <= 1'b1;
              buf_byte <= rx_byte;
              buf_tag  <= req_tag;
              buf_vld  <= 1'b1;
              rsp_data <= sel_lo ? rx_byte[3:0]
                                 : rx_byte[7:4];
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              tx_sr    <= {tx_sr[30:0], 1'b0};
              spi_mosi <= tx_sr[30];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_nibble_spi_fetch.sv
// Bench for cpu_nibble_spi_fetch: flash model, reference model of the
// line buffer, and a scoreboard monitor checking pins and responses.
module tb_cpu_nibble_spi_fetch;

  typedef struct {
    int          inst;
    bit          miss;
    int          due;
    logic [31:0] cmd;
    logic [3:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  inv;
  logic [1:0]  rsp_valid;
  logic [1:0]  cs_n;
  logic [1:0]  sck;
  logic [1:0]  mosi;
  logic [11:0] req_addr [2];
  logic [3:0]  rsp_data [2];

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        mvld [2];
  logic [10:0] mtag [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] v;
    v = (a[7:0] * 8'd29) + a[15:8];
    v = v ^ a[23:16] ^ 8'h96;
    if (a == 24'h000152) v = 8'hC5;
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        miso_r = 1'b0;
    int          nb = 0;
    logic [31:0] sh = '0;
    logic [7:0]  db = '0;

    cpu_nibble_spi_fetch #(
      .BASE_ADDR((g == 1) ? 24'hFFFFFF : 24'h000000),
      .CACHE_EN (g == 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .inv      (inv[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_data (rsp_data[g]),
      .spi_cs_n (cs_n[g]),
      .spi_sck  (sck[g]),
      .spi_mosi (mosi[g]),
      .spi_miso (miso_r)
    );

    // Flash: decode command/address from MOSI, return the byte MSB first
    always @(posedge sck[g] or posedge cs_n[g]) begin
      if (cs_n[g]) begin
        nb     <= 0;
        miso_r <= 1'b0;
      end else begin
        nb <= nb + 1;
        sh <= {sh[30:0], mosi[g]};
        if (nb == 31) db <= flash_byte({sh[22:0], mosi[g]});
        if (nb >= 32 && nb < 40) miso_r <= db[39 - nb];
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc %0d: got %h required %h",
               nm, i, cyc, act, exp);
    end
  endtask

  // Monitor: expected pin activity and responses from the queue front
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        own;
      logic        ecs, esck, emosi, erdy;
      logic [31:0] c;
      int          k;
      int          st;
      own   = (q.size() > 0) && (q[0].inst == i);
      ecs   = 1'b1;
      esck  = 1'b0;
      emosi = 1'b0;
      erdy  = !own;
      if (own && q[0].miss) begin
        st = q[0].due - 80;
        c  = q[0].cmd;
        if (cyc >= st && cyc < q[0].due) begin
          k     = cyc - st;
          ecs   = 1'b0;
          esck  = k[0];
          emosi = (k / 2 < 32) ? c[31 - k / 2] : 1'b0;
        end
      end
      chk("pins cs/sck/mosi/ready", i,
          {4'b0, cs_n[i], sck[i], mosi[i], req_ready[i]},
          {4'b0, ecs, esck, emosi, erdy});
      if (own && cyc == q[0].due) begin
        chk("rsp valid/data", i, {3'b0, rsp_valid[i], rsp_data[i]},
            {3'b0, 1'b1, q[0].data});
        void'(q.pop_front());
      end else begin
        chk("no rsp", i, {7'b0, rsp_valid[i]}, 8'd0);
      end
      if (!rst_n) chk("reset rsp_data", i, {4'b0, rsp_data[i]}, 8'd0);
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      g++;
      if (g > 300) begin
        $display("FAIL wait_idle: queue size %0d required 0", q.size());
        $fatal(1, "scoreboard stuck");
      end
    end
  endtask

  task automatic issue(input int i, input logic [11:0] a,
                       input logic iv);
    exp_t        e;
    logic [23:0] ba;
    logic [7:0]  b;
    logic        hit;
    wait_idle();
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    inv[i]       = iv;
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    inv[i]       = 1'b0;
    ba  = ((i == 1) ? 24'hFFFFFF : 24'h000000) + {13'b0, a[11:1]};
    b   = flash_byte(ba);
    hit = (i == 0) && mvld[i] && !iv && (mtag[i] == a[11:1]);
    if (!hit) begin
      mvld[i] = 1'b1;
      mtag[i] = a[11:1];
    end
    e.inst = i;
    e.miss = !hit;
    e.due  = hit ? cyc : cyc + 80;
    e.cmd  = {8'h03, ba};
    e.data = a[0] ? b[3:0] : b[7:4];
    q.push_back(e);
  endtask

  task automatic pulse_inv(input int i, input bit busy);
    @(negedge clk);
    inv[i] = 1'b1;
    @(posedge clk);
    #1;
    inv[i] = 1'b0;
    if (!busy) mvld[i] = 1'b0;
  endtask

  initial begin
    logic [11:0] a;
    logic [11:0] last;
    logic        iv;
    req_valid   = '0;
    inv         = '0;
    req_addr[0] = '0;
    req_addr[1] = '0;
    mvld[0]     = 1'b0;
    mvld[1]     = 1'b0;
    mtag[0]     = '0;
    mtag[1]     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    issue(0, 12'h2A4, 1'b0);
    issue(0, 12'h2A5, 1'b0);
    issue(0, 12'h2A5, 1'b1);
    issue(0, 12'h2A4, 1'b0);
    wait_idle();
    pulse_inv(0, 1'b0);
    issue(0, 12'h2A5, 1'b0);
    issue(1, 12'h002, 1'b0);
    issue(1, 12'h003, 1'b0);
    issue(1, 12'hFFF, 1'b0);

    issue(0, 12'h3F0, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    mvld[0] = 1'b0;
    mvld[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 12'h3F0, 1'b0);
    issue(0, 12'h3F1, 1'b0);

    last = 12'h3F1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        a = {last[11:1], 1'($urandom_range(0, 1))};
      else if ($urandom_range(0, 3) == 0)
        a = 12'($urandom);
      else
        a = 12'($urandom_range(0, 15));
      iv = ($urandom_range(0, 7) == 0);
      issue(0, a, iv);
      last = a;
      if (q.size() > 0 && q[0].miss && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(5, 60)) @(negedge clk);
        pulse_inv(0, 1'b1);
      end
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        pulse_inv(0, 1'b0);
      end
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
